// File: rtl/acia_fifo.sv
// 6551-register-compatible ACIA with RX/TX FIFOs and an internal 16x baud generator.
// Define ACIA_HW_FLOW_EN to enable RTS/CTS hardware flow control.

module acia_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [7:0]              din,
    input  logic                    pop,
    output logic [7:0]              head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module acia_fifo #(
    parameter int CLK_HZ         = 54000000,
    parameter int RX_DEPTH       = 16,
    parameter int TX_DEPTH       = 16,
    parameter int RX_SYNC_STAGES = 2
) (
    input  logic       clk_logic_i,
    input  logic       reset_i,
    input  logic       strobe_i,
    input  logic       cs_i,
    input  logic       rw_n_i,
    input  logic [1:0] rs_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_n_o,
    input  logic       uart_rx_i,
    output logic       uart_tx_o,
    input  logic       cts_n_i,
    output logic       rts_n_o,
    output logic       dtr_n_o
);
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam logic [RCW-1:0] RX_FULL = RX_DEPTH[RCW-1:0];
    localparam logic [TCW-1:0] TX_FULL = TX_DEPTH[TCW-1:0];

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [31:0] baud_div(input logic [3:0] idx);
        int rate;
        rate = 115200;
        case (idx)
            4'd1:  rate = 50;
            4'd2:  rate = 75;
            4'd3:  rate = 110;
            4'd4:  rate = 135;
            4'd5:  rate = 150;
            4'd6:  rate = 300;
            4'd7:  rate = 600;
            4'd8:  rate = 1200;
            4'd9:  rate = 1800;
            4'd10: rate = 2400;
            4'd11: rate = 3600;
            4'd12: rate = 4800;
            4'd13: rate = 7200;
            4'd14: rate = 9600;
            4'd15: rate = 19200;
            default: rate = 115200;
        endcase
        return 32'((CLK_HZ + 8 * rate) / (16 * rate) - 1);
    endfunction

    logic [7:0] control, command, last_rx;
    logic       overrun, framing, tx_irq, tx_empty_d;
    logic       access, wr_data, wr_control, wr_command, prog_reset, rd_data, rd_status;
    logic [7:0] tx_head, rx_head, status;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    logic       tx_empty, rx_empty, tdre, rdrf, irq, brk, tx_go, tx_pop;
    logic [31:0] baud_cnt;
    logic       tick;
    logic [RX_SYNC_STAGES-1:0] rx_sync;
    logic       rx_s, rx_prev;

    tx_state_t  tx_state;
    logic [3:0] tx_tick;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_stop2, tx_line;

    rx_state_t  rx_state;
    logic [3:0] rx_tick;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_push, rx_ferr;

    assign access     = strobe_i && cs_i;
    assign wr_data    = access && !rw_n_i && (rs_i == 2'd0);
    assign prog_reset = access && !rw_n_i && (rs_i == 2'd1);
    assign wr_command = access && !rw_n_i && (rs_i == 2'd2);
    assign wr_control = access && !rw_n_i && (rs_i == 2'd3);
    assign rd_data    = access && rw_n_i && (rs_i == 2'd0);
    assign rd_status  = access && rw_n_i && (rs_i == 2'd1);

    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);
    assign tdre     = (tx_count != TX_FULL);
    assign rdrf     = !rx_empty;
    assign brk      = (command[3:2] == 2'b11);
    assign irq      = (rdrf && !command[1] && command[0]) || tx_irq;
    assign status   = {irq, 2'b00, tdre, rdrf, overrun, framing, 1'b0};
    assign irq_n_o  = !irq;
    assign dtr_n_o  = !command[0];
    assign uart_tx_o = tx_line;

    always_comb begin
        data_o = 8'h00;
        if (cs_i && rw_n_i) begin
            case (rs_i)
                2'd0: data_o = rx_empty ? last_rx : rx_head;
                2'd1: data_o = status;
                2'd2: data_o = command;
                2'd3: data_o = control;
                default: data_o = 8'h00;
            endcase
        end
    end

    acia_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk_logic_i), .rst(reset_i), .flush(prog_reset),
        .push(wr_data), .din(data_i), .pop(tx_pop), .head(tx_head), .count(tx_count)
    );

    acia_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk_logic_i), .rst(reset_i), .flush(prog_reset),
        .push(rx_push), .din(rx_shift), .pop(rd_data), .head(rx_head), .count(rx_count)
    );

    // Later assignments win: a new error event is never lost to a same-cycle clear.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            control    <= 8'h00;
            command    <= 8'h00;
            last_rx    <= 8'h00;
            overrun    <= 1'b0;
            framing    <= 1'b0;
            tx_irq     <= 1'b0;
            tx_empty_d <= 1'b1;
        end else begin
            tx_empty_d <= tx_empty;
            if (wr_control) control <= data_i;
            if (wr_command) command <= data_i;
            if (rd_data) begin
                framing <= 1'b0;
                if (!rx_empty) last_rx <= rx_head;
            end
            if (rd_status) begin
                overrun <= 1'b0;
                tx_irq  <= 1'b0;
            end
            if (wr_data) tx_irq <= 1'b0;
            if (tx_empty && !tx_empty_d && command[3:2] == 2'b01) tx_irq <= 1'b1;
            if (rx_push && rx_count == RX_FULL) overrun <= 1'b1;
            if (rx_push && rx_ferr) framing <= 1'b1;
            if (prog_reset) begin
                command[4:0] <= 5'd0;
                overrun      <= 1'b0;
                framing      <= 1'b0;
                tx_irq       <= 1'b0;
            end
        end
    end

    assign tick = (baud_cnt == 32'd0);

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i)         baud_cnt <= baud_div(4'd0);
        else if (wr_control) baud_cnt <= baud_div(data_i[3:0]);
        else if (tick)       baud_cnt <= baud_div(control[3:0]);
        else                 baud_cnt <= baud_cnt - 1'b1;
    end

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= (rx_sync << 1) | RX_SYNC_STAGES'(uart_rx_i);
            rx_prev <= rx_s;
        end
    end
    assign rx_s = rx_sync[RX_SYNC_STAGES-1];

`ifdef ACIA_HW_FLOW_EN
    localparam int RTS_HI_I = RX_DEPTH - 2;
    localparam int RTS_LO_I = RX_DEPTH / 2;
    localparam logic [RCW-1:0] RTS_HI = RTS_HI_I[RCW-1:0];
    localparam logic [RCW-1:0] RTS_LO = RTS_LO_I[RCW-1:0];
    logic [RX_SYNC_STAGES-1:0] cts_sync;
    logic cts_s, rts_hold;

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            cts_sync <= '1;
            rts_hold <= 1'b0;
        end else begin
            cts_sync <= (cts_sync << 1) | RX_SYNC_STAGES'(cts_n_i);
            if (rx_count >= RTS_HI)      rts_hold <= 1'b1;
            else if (rx_count <= RTS_LO) rts_hold <= 1'b0;
        end
    end
    assign cts_s   = cts_sync[RX_SYNC_STAGES-1];
    assign rts_n_o = (command[3:2] == 2'b00) || rts_hold;
`else
    logic cts_s;
    assign cts_s   = 1'b0;
    assign rts_n_o = (command[3:2] == 2'b00);
`endif

    always_comb begin
        tx_go = !tx_empty && (command[3:2] == 2'b01 || command[3:2] == 2'b10) && !prog_reset;
`ifdef ACIA_HW_FLOW_EN
        tx_go = tx_go && !cts_s;
`endif
    end
    assign tx_pop = tick && (tx_state == TX_IDLE) && tx_go;

    // Break is applied at bit boundaries; a running frame keeps its timing under it.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state <= TX_IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            tx_stop2 <= 1'b0;
            tx_line  <= 1'b1;
        end else if (tick) begin
            tx_tick <= tx_tick + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_go) begin
                        tx_state <= TX_START;
                        tx_shift <= tx_head;
                        tx_stop2 <= control[7];
                        tx_tick  <= 4'd0;
                        tx_line  <= 1'b0;
                    end else if (tx_tick == 4'd15) begin
                        tx_line <= !brk;
                    end
                end
                TX_START: begin
                    if (tx_tick == 4'd15) begin
                        tx_state <= TX_DATA;
                        tx_bit   <= 3'd0;
                        tx_line  <= tx_shift[0] && !brk;
                    end
                end
                TX_DATA: begin
                    if (tx_tick == 4'd15) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx_line  <= !brk;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1] && !brk;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick == 4'd15) begin
                        if (tx_stop2) tx_stop2 <= 1'b0;
                        else          tx_state <= TX_IDLE;
                        tx_line <= !brk;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state <= RX_IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_push  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (!command[0]) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_s) begin
                            rx_state <= RX_START_CHK;
                            rx_tick  <= 4'd0;
                        end
                    end
                    RX_START_CHK: begin
                        if (tick) begin
                            rx_tick <= rx_tick + 1'b1;
                            if (rx_tick == 4'd7) begin
                                rx_tick  <= 4'd0;
                                rx_bit   <= 3'd0;
                                rx_state <= rx_s ? RX_IDLE : RX_DATA;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            rx_tick <= rx_tick + 1'b1;
                            if (rx_tick == 4'd15) begin
                                rx_shift <= {rx_s, rx_shift[7:1]};
                                rx_bit   <= rx_bit + 1'b1;
                                if (rx_bit == 3'd7) rx_state <= RX_STOP;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (tick) begin
                            rx_tick <= rx_tick + 1'b1;
                            if (rx_tick == 4'd15) begin
                                rx_push  <= 1'b1;
                                rx_ferr  <= !rx_s;
                                rx_state <= RX_IDLE;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acia_fifo.sv
// Scoreboard bench for acia_fifo: register reads are checked by a monitor against queued
// expectations; serial-line and pin behaviour is checked directly by the stimulus process.
`timescale 1ns/1ps
module tb_acia_fifo;
    localparam int CLK_HZ  = 1843200;  // 115200 baud -> tick every cycle, 9600 -> every 12
    localparam int RX_BIT  = 16;       // cycles per bit at 115200
    localparam int TX_BIT9600 = 192;   // cycles per bit at 9600

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0, cs = 1'b0, rw_n = 1'b1;
    logic [1:0] rs = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq_n, tx, rts_n, dtr_n;
    logic       rx = 1'b1;
    logic       cts_n = 1'b0;

    always #5 clk = ~clk;

    acia_fifo #(.CLK_HZ(CLK_HZ), .RX_DEPTH(16), .TX_DEPTH(16), .RX_SYNC_STAGES(2)) dut (
        .clk_logic_i(clk), .reset_i(rst), .strobe_i(strobe), .cs_i(cs), .rw_n_i(rw_n),
        .rs_i(rs), .data_i(din), .data_o(dout), .irq_n_o(irq_n), .uart_rx_i(rx),
        .uart_tx_o(tx), .cts_n_i(cts_n), .rts_n_o(rts_n), .dtr_n_o(dtr_n)
    );

    typedef struct {
        string      name;
        logic [7:0] value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, want);
        end
    endtask

    // Monitor: every read access presents data_o; compare it against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (strobe && cs && rw_n) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got 0x%02h with no expectation queued", dout);
            end else begin
                e = sb.pop_front();
                check(e.name, dout, e.value);
            end
        end
    end

    task automatic bus_write(input logic [1:0] r, input logic [7:0] d);
        @(posedge clk); #2;
        strobe = 1'b1; cs = 1'b1; rw_n = 1'b0; rs = r; din = d;
        @(posedge clk); #2;
        strobe = 1'b0; cs = 1'b0; rw_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] r, input logic [7:0] want, input string name);
        exp_t e;
        e.name = name;
        e.value = want;
        sb.push_back(e);
        @(posedge clk); #2;
        strobe = 1'b1; cs = 1'b1; rw_n = 1'b1; rs = r;
        @(posedge clk); #2;
        strobe = 1'b0; cs = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (RX_BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (RX_BIT) @(posedge clk);
        end
        rx = stop;
        repeat (RX_BIT) @(posedge clk);
        rx = 1'b1;
        repeat (2 * RX_BIT) @(posedge clk);
    endtask

    // Waits for the start bit of a frame whose bit 0 is 1, checks the start-bit length and
    // samples each data bit and the stop bit at its mid-point.
    task automatic check_tx_frame(input logic [7:0] b, input int bit_cyc, input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 40 * bit_cyc) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_start: no start bit within %0d cycles", tag, n);
            return;
        end
        n = 0;
        while (tx === 1'b0 && n < 2 * bit_cyc) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < bit_cyc - bit_cyc / 16 || n > bit_cyc + bit_cyc / 16) begin
            bad++;
            $display("FAIL %s_start_len: got %0d cycles expected %0d +/- %0d", tag, n, bit_cyc, bit_cyc / 16);
        end
        repeat (bit_cyc / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_bit%0d", tag, i), {7'b0, tx}, {7'b0, b[i]});
            repeat (bit_cyc) @(negedge clk);
        end
        check($sformatf("%s_stop", tag), {7'b0, tx}, 8'h01);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_low;

        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_irq_n", {7'b0, irq_n}, 8'h01);
        check("rst_dtr_n", {7'b0, dtr_n}, 8'h01);
        check("rst_rts_n", {7'b0, rts_n}, 8'h01);
        check("rst_data_o", dout, 8'h00);
        bus_read(2'd1, 8'h10, "rst_status");
        bus_read(2'd2, 8'h00, "rst_command");

        // 9600 baud transmit of 0x55
        bus_write(2'd3, 8'h1E);
        bus_write(2'd2, 8'h0B);
        @(negedge clk);
        check("cmd0b_rts_n", {7'b0, rts_n}, 8'h00);
        check("cmd0b_dtr_n", {7'b0, dtr_n}, 8'h00);
        bus_write(2'd0, 8'h55);
        check_tx_frame(8'h55, TX_BIT9600, "tx55");
        bus_read(2'd1, 8'h10, "tx55_status");

        // 17 bytes into a 16-deep RX FIFO at 115200
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        @(negedge clk);
        check("rxfull_irq_masked", {7'b0, irq_n}, 8'h01);
        for (int i = 0; i < 16; i++) bus_read(2'd0, 8'(i), $sformatf("rx_byte%0d", i));
        bus_read(2'd1, 8'h14, "rx_overrun_status");
        bus_read(2'd1, 8'h10, "rx_overrun_cleared");
        bus_read(2'd0, 8'h0F, "rx_empty_last_byte");

        // receive interrupt and framing error
        bus_write(2'd2, 8'h09);
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        check("rx_irq_asserted", {7'b0, irq_n}, 8'h00);
        bus_read(2'd0, 8'hA5, "rx_a5");
        @(negedge clk);
        check("rx_irq_released", {7'b0, irq_n}, 8'h01);
        send_byte(8'h3C, 1'b0);
        bus_read(2'd1, 8'h9A, "framing_status");
        bus_read(2'd0, 8'h3C, "framing_byte");
        bus_read(2'd1, 8'h10, "framing_cleared");

        // glitch rejection
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (60) @(posedge clk);
        bus_read(2'd1, 8'h10, "glitch_status");
        @(negedge clk);
        check("glitch_irq_n", {7'b0, irq_n}, 8'h01);

        // TX-empty interrupt
        bus_write(2'd2, 8'h05);
        @(negedge clk);
        check("txirq_idle", {7'b0, irq_n}, 8'h01);
        bus_write(2'd0, 8'h11);
        repeat (10) @(negedge clk);
        check("txirq_set", {7'b0, irq_n}, 8'h00);
        bus_read(2'd1, 8'h90, "txirq_status");
        @(negedge clk);
        check("txirq_cleared", {7'b0, irq_n}, 8'h01);
        repeat (200) @(posedge clk);

        // break
        bus_write(2'd2, 8'h0D);
        repeat (40) @(negedge clk);
        check("break_low", {7'b0, tx}, 8'h00);
        bus_write(2'd2, 8'h0B);
        repeat (40) @(negedge clk);
        check("break_release", {7'b0, tx}, 8'h01);

        // programmed reset, TX full
        bus_write(2'd2, 8'hEB);
        bus_write(2'd3, 8'h20);
        bus_write(2'd1, 8'h00);
        bus_read(2'd2, 8'hE0, "progrst_command");
        bus_read(2'd3, 8'h20, "progrst_control");
        @(negedge clk);
        check("progrst_dtr_n", {7'b0, dtr_n}, 8'h01);
        check("progrst_rts_n", {7'b0, rts_n}, 8'h01);
        for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(8'h80 + i));
        bus_read(2'd1, 8'h00, "txfull_status");
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, 8'h10, "txflush_status");
        @(negedge clk);
        check("txflush_line_idle", {7'b0, tx}, 8'h01);

        bus_write(2'd3, 8'h00);
        bus_write(2'd2, 8'h0B);
`ifdef ACIA_HW_FLOW_EN
        cts_n = 1'b1;
        bus_write(2'd0, 8'h41);
        seen_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tx === 1'b0) seen_low = 1'b1;
        end
        check("flow_tx_held", {7'b0, seen_low}, 8'h00);
        cts_n = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 24) begin
            @(negedge clk);
            n++;
        end
        check("flow_tx_started", {7'b0, tx}, 8'h00);
        repeat (200) @(posedge clk);
        for (int i = 0; i < 14; i++) send_byte(8'(i), 1'b1);
        @(negedge clk);
        check("flow_rts_high", {7'b0, rts_n}, 8'h01);
        for (int i = 0; i < 5; i++) bus_read(2'd0, 8'(i), $sformatf("flow_rx%0d", i));
        @(negedge clk);
        check("flow_rts_hyst", {7'b0, rts_n}, 8'h01);
        bus_read(2'd0, 8'h05, "flow_rx5");
        @(negedge clk);
        check("flow_rts_low", {7'b0, rts_n}, 8'h00);
        for (int i = 6; i < 14; i++) bus_read(2'd0, 8'(i), $sformatf("flow_rx%0d", i));
`else
        cts_n = 1'b1;
        bus_write(2'd0, 8'h41);
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("cts_ignored_tx_started", {7'b0, tx}, 8'h00);
        check("cts_ignored_rts_n", {7'b0, rts_n}, 8'h00);
        repeat (200) @(posedge clk);
`endif

        repeat (4) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
